// File: rtl/perf_pkg.sv
// Shared definitions for the performance event monitor.
//   perfStateT : FSM state encoding (RUN=0, DUMP=1, DONE=2)
//   IDX_*      : fixed counter slots (cycles, instructions, first event)
package perf_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DUMP = 2'd1,
    ST_DONE = 2'd2
  } perfStateT;

  localparam int unsigned IDX_CYCLE = 0;
  localparam int unsigned IDX_INST  = 1;
  localparam int unsigned IDX_EVT0  = 2;

endpackage

// File: rtl/perf_event_monitor_cell.sv
// Single performance counter with sticky overflow flag.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   inc      : add one this cycle
//   clr      : zero counter and flag (wins over inc)
//   frz      : hold everything (wins over clr and inc)
//   cnt      : counter value
//   ovf      : set by an increment from all-ones, sticky until clr/rst
module perf_counter_cell #(
  parameter int unsigned CNT_W    = 32,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic             frz,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (!frz) begin
      if (clr) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else if (inc) begin
        if (&cnt) begin
          ovf <= 1'b1;
          // Saturating mode leaves cnt at all-ones.
          if (!SATURATE) cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/perf_event_monitor.sv
// Performance event monitor: cycle, retired-instruction and NUM_EVT event
// counters. A halt freezes the counters and streams them out on the dump port.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   enable            : counting enable
//   retire, halt      : writeback-stage retire / halt strobes
//   evt               : per-channel event strobes
//   clr               : zero counters and flags (RUN only)
//   rd_idx / rd_data  : combinational random-access read (0 when out of range)
//   ovf               : sticky per-counter overflow flags
//   dump_*            : valid/ready stream of all counters after halt
//   state             : FSM state (RUN=0, DUMP=1, DONE=2)
module perf_event_monitor
  import perf_pkg::*;
#(
  parameter int unsigned NUM_EVT  = 4,
  parameter int unsigned CNT_W    = 32,
  parameter bit          SATURATE = 1'b1,
  localparam int unsigned NUM_CNT = NUM_EVT + 2,
  localparam int unsigned IDX_W   = $clog2(NUM_CNT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               retire,
  input  logic               halt,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               clr,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [CNT_W-1:0]   rd_data,
  output logic [NUM_CNT-1:0] ovf,
  output logic               dump_valid,
  input  logic               dump_ready,
  output logic [IDX_W-1:0]   dump_idx,
  output logic [CNT_W-1:0]   dump_data,
  output logic               dump_done,
  output logic [1:0]         state
);

  perfStateT        stateQ, stateD;
  logic [IDX_W-1:0] dumpIdxQ, dumpIdxD;
  logic [NUM_CNT-1:0] incVec;
  logic [CNT_W-1:0]   cntVal [NUM_CNT];
  logic               frz;

  // Halt counts as one retired instruction, never two.
  assign incVec[IDX_CYCLE]              = enable;
  assign incVec[IDX_INST]               = enable & (retire | halt);
  assign incVec[IDX_EVT0 +: NUM_EVT]    = {NUM_EVT{enable}} & evt;

  // Freezing outside RUN also masks clr there.
  assign frz = (stateQ != ST_RUN);

  for (genvar i = 0; i < NUM_CNT; i++) begin : gCell
    perf_counter_cell #(
      .CNT_W   (CNT_W),
      .SATURATE(SATURATE)
    ) uCell (
      .clk(clk),
      .rst(rst),
      .inc(incVec[i]),
      .clr(clr),
      .frz(frz),
      .cnt(cntVal[i]),
      .ovf(ovf[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ   <= ST_RUN;
      dumpIdxQ <= '0;
    end else begin
      stateQ   <= stateD;
      dumpIdxQ <= dumpIdxD;
    end
  end

  always_comb begin
    stateD     = stateQ;
    dumpIdxD   = dumpIdxQ;
    dump_valid = 1'b0;
    dump_done  = 1'b0;
    unique case (stateQ)
      ST_RUN: begin
        if (halt) stateD = ST_DUMP;
      end
      ST_DUMP: begin
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (dumpIdxQ == IDX_W'(NUM_CNT - 1)) stateD = ST_DONE;
          else dumpIdxD = dumpIdxQ + IDX_W'(1);
        end
      end
      ST_DONE: begin
        dump_done = 1'b1;
      end
      default: stateD = ST_RUN;
    endcase
  end

  // Explicit compare mux so out-of-range indices read as zero.
  always_comb begin
    rd_data   = '0;
    dump_data = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_idx == IDX_W'(i))   rd_data   = cntVal[i];
      if (dumpIdxQ == IDX_W'(i)) dump_data = cntVal[i];
    end
  end

  assign dump_idx = dumpIdxQ;
  assign state    = stateQ;

endmodule

// File: tb/tb_perf_event_monitor.sv
// Directed bench for perf_event_monitor: one default instance plus two 8-bit
// instances (saturating and wrapping) for the overflow cases.
module tb_perf_event_monitor;

  localparam int unsigned NE = 4;
  localparam int unsigned NC = 6;
  localparam int unsigned IW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic          rst = 1'b1, enable = 1'b1, retire = 1'b0, halt = 1'b0, clr = 1'b0;
  logic [NE-1:0] evt = '0;
  logic [IW-1:0] rdIdx = '0;
  logic [31:0]   rdData, dumpData;
  logic [NC-1:0] ovf;
  logic          dumpValid, dumpReady = 1'b0, dumpDone;
  logic [IW-1:0] dumpIdx;
  logic [1:0]    state;

  // 8-bit instances
  logic          rst8 = 1'b1, enable8 = 1'b0, zero8 = 1'b0;
  logic [NE-1:0] evt8 = '0;
  logic [IW-1:0] rdIdx8 = '0;
  logic [7:0]    rdSat, rdWrap, dDataSat, dDataWrap;
  logic [NC-1:0] ovfSat, ovfWrap;
  logic          dValidSat, dValidWrap, dDoneSat, dDoneWrap;
  logic [IW-1:0] dIdxSat, dIdxWrap;
  logic [1:0]    stSat, stWrap;

  int total = 0;
  int bad   = 0;

  perf_event_monitor #(.NUM_EVT(NE), .CNT_W(32), .SATURATE(1'b1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .retire(retire), .halt(halt), .evt(evt),
    .clr(clr), .rd_idx(rdIdx), .rd_data(rdData), .ovf(ovf), .dump_valid(dumpValid),
    .dump_ready(dumpReady), .dump_idx(dumpIdx), .dump_data(dumpData),
    .dump_done(dumpDone), .state(state)
  );

  perf_event_monitor #(.NUM_EVT(NE), .CNT_W(8), .SATURATE(1'b1)) dutSat (
    .clk(clk), .rst(rst8), .enable(enable8), .retire(zero8), .halt(zero8), .evt(evt8),
    .clr(zero8), .rd_idx(rdIdx8), .rd_data(rdSat), .ovf(ovfSat), .dump_valid(dValidSat),
    .dump_ready(zero8), .dump_idx(dIdxSat), .dump_data(dDataSat),
    .dump_done(dDoneSat), .state(stSat)
  );

  perf_event_monitor #(.NUM_EVT(NE), .CNT_W(8), .SATURATE(1'b0)) dutWrap (
    .clk(clk), .rst(rst8), .enable(enable8), .retire(zero8), .halt(zero8), .evt(evt8),
    .clr(zero8), .rd_idx(rdIdx8), .rd_data(rdWrap), .ovf(ovfWrap), .dump_valid(dValidWrap),
    .dump_ready(zero8), .dump_idx(dIdxWrap), .dump_data(dDataWrap),
    .dump_done(dDoneWrap), .state(stWrap)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkRd(input string tag, input logic [IW-1:0] idx, input logic [63:0] exp);
    rdIdx = idx;
    #1;
    chk(tag, 64'(rdData), exp);
  endtask

  int unsigned expDump [NC] = '{21, 4, 3, 0, 0, 1};

  initial begin
    // 1: reset then idle count
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chkRd("t1_cycles", 3'd0, 10);
    chkRd("t1_inst", 3'd1, 0);
    chk("t1_ovf", 64'(ovf), 0);
    chk("t1_state", 64'(state), 0);

    // 2: retire and overlapping event 1
    retire = 1'b1; evt = 4'b0000;
    repeat (3) tick();
    evt = 4'b0010;
    repeat (2) tick();
    retire = 1'b0;
    tick();
    evt = 4'b0000;
    chkRd("t2_inst", 3'd1, 5);
    chkRd("t2_evt1", 3'd3, 3);
    chkRd("t2_evt0", 3'd2, 0);
    tick();
    chkRd("t2_evt2", 3'd4, 0);
    chkRd("t2_evt3", 3'd5, 0);
    chkRd("t2_oob", 3'd7, 0);
    chkRd("t2_cycles", 3'd0, 17);

    // enable low holds counters
    retire = 1'b1;
    repeat (2) tick();
    chkRd("t4_inst7", 3'd1, 7);
    enable = 1'b0; evt = 4'b1111;
    repeat (3) tick();
    chkRd("en0_inst", 3'd1, 7);
    chkRd("en0_evt0", 3'd2, 0);
    enable = 1'b1; retire = 1'b0; evt = 4'b0000;

    // 4: clr beats same-cycle increments
    clr = 1'b1; retire = 1'b1; evt = 4'b0010;
    tick();
    clr = 1'b0; retire = 1'b0; evt = 4'b0000;
    chkRd("t4_clr_cycles", 3'd0, 0);
    chkRd("t4_clr_inst", 3'd1, 0);
    chkRd("t4_clr_evt1", 3'd3, 0);
    chk("t4_clr_ovf", 64'(ovf), 0);

    // 5: run to 20 cycles, halt, dump with stalls
    repeat (17) tick();
    retire = 1'b1; evt = 4'b0001;
    repeat (3) tick();
    retire = 1'b0; evt = 4'b1000; halt = 1'b1;
    tick();
    halt = 1'b0; evt = 4'b0000;
    chk("t5_state_dump", 64'(state), 1);
    clr = 1'b1; halt = 1'b1; retire = 1'b1; evt = 4'b1111;
    tick();
    clr = 1'b0; halt = 1'b0; retire = 1'b0; evt = 4'b0000;
    chkRd("t4_dump_clr_cycles", 3'd0, 21);
    chkRd("t5_inst_halt", 3'd1, 4);
    for (int i = 0; i < NC; i++) begin
      chk("t5_valid", 64'(dumpValid), 1);
      chk("t5_idx", 64'(dumpIdx), 64'(i));
      chk("t5_data", 64'(dumpData), 64'(expDump[i]));
      dumpReady = 1'b0;
      tick();
      chk("t5_idx_stall", 64'(dumpIdx), 64'(i));
      chk("t5_data_stall", 64'(dumpData), 64'(expDump[i]));
      dumpReady = 1'b1;
      tick();
    end
    dumpReady = 1'b0;
    chk("t5_state_done", 64'(state), 2);
    chk("t5_done", 64'(dumpDone), 1);
    chk("t5_valid_off", 64'(dumpValid), 0);
    repeat (3) tick();
    chkRd("t5_frozen_cycles", 3'd0, 21);
    chkRd("t5_frozen_evt3", 3'd5, 1);

    // 6: reset in the middle of a dump
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    dumpReady = 1'b1;
    repeat (3) tick();
    dumpReady = 1'b0;
    chk("t6_idx3", 64'(dumpIdx), 3);
    chk("t6_valid", 64'(dumpValid), 1);
    rst = 1'b1;
    tick();
    chk("t6_state", 64'(state), 0);
    chk("t6_valid_off", 64'(dumpValid), 0);
    chk("t6_done_off", 64'(dumpDone), 0);
    chk("t6_idx0", 64'(dumpIdx), 0);
    chkRd("t6_cycles", 3'd0, 0);
    chkRd("t6_inst", 3'd1, 0);
    rst = 1'b0;

    // 3: 8-bit overflow, saturating vs wrapping
    rst8 = 1'b0; enable8 = 1'b1; evt8 = 4'b0001;
    repeat (300) tick();
    enable8 = 1'b0; evt8 = 4'b0000;
    rdIdx8 = 3'd2;
    #1;
    chk("t3_sat_evt0", 64'(rdSat), 255);
    chk("t3_sat_ovf", 64'(ovfSat), 64'h5);
    chk("t3_wrap_evt0", 64'(rdWrap), 44);
    chk("t3_wrap_ovf", 64'(ovfWrap), 64'h5);
    rdIdx8 = 3'd0;
    #1;
    chk("t3_wrap_cycles", 64'(rdWrap), 44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/perf_event_monitor.md
Name: perf_event_monitor

Overview:
- Synthesizable, parametrised performance-monitoring block for the pipelined CPU.
- Counts cycles, retired instructions and NUM_EVT generic events (I/D cache requests and hits, stalls, flushes).
- Halt freezes all counters. The block then streams every counter out over a valid/ready dump port.
- Attaches beside the pipeline core and is driven by the writeback-stage retire/halt signals and the cache event strobes.

Parameters:
NUM_EVT, 4, number of generic event channels (1..14)
CNT_W, 32, counter width in bits (8..64)
SATURATE, 1, 1 = counters saturate at all-ones; 0 = counters wrap to 0
NUM_CNT (localparam), NUM_EVT+2, total counters: index 0 = cycles, index 1 = instructions, index 2+k = event k
IDX_W (localparam), $clog2(NUM_CNT), counter index width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  counting enable; when low, all counters hold
retire  in  1  one instruction retired this cycle (RegWrite | MemWrite | halt at WB)
halt  in  1  processor halt/error reached WB
evt  in  NUM_EVT  per-channel event strobes, one count per cycle high
clr  in  1  zero all counters and overflow flags (RUN state only)
rd_idx  in  IDX_W  random-access read select
rd_data  out  CNT_W  counter[rd_idx], combinational; 0 if rd_idx >= NUM_CNT
ovf  out  NUM_CNT  sticky per-counter overflow/saturation flags
dump_valid  out  1  dump word valid
dump_ready  in  1  consumer accepts dump word
dump_idx  out  IDX_W  index of the current dump word
dump_data  out  CNT_W  value of the current dump word
dump_done  out  1  all counters dumped
state  out  2  FSM state (RUN=0, DUMP=1, DONE=2)

Behaviour:
- Reset (rst=1 at posedge):
  - All counters and ovf go to 0; state=RUN.
  - dump_valid=0, dump_idx=0, dump_done=0.
  - Reset has priority over everything, including a dump in progress.
- RUN state, with enable=1, each cycle:
  - cycle counter +1.
  - Instruction counter +1 if retire | halt. A halt cycle counts as one instruction; retire and halt in the same cycle still add only 1.
  - Event counter k +1 if evt[k].
  - Updates are visible on rd_data the following cycle.
- enable=0: no counter changes. halt is still honoured.
- clr in RUN:
  - All counters and ovf become 0 next cycle.
  - clr takes priority over same-cycle increments; that cycle is not counted.
  - clr is ignored in DUMP and DONE.
- Overflow:
  - An increment from all-ones sets ovf[i] (sticky until clr or rst).
  - SATURATE=1: the counter stays all-ones.
  - SATURATE=0: the counter wraps to 0.
- RUN -> DUMP on halt=1 (regardless of enable):
  - The halt cycle's increments are applied, subject to enable.
  - Counters then freeze for the rest of DUMP and DONE.
- DUMP state:
  - dump_valid=1, dump_data=counter[dump_idx], starting at dump_idx=0.
  - On dump_valid & dump_ready: dump_idx+1.
  - When index NUM_CNT-1 is accepted: go to DONE, dump_valid=0.
  - dump_data and dump_idx stay stable while dump_ready=0.
  - halt while in DUMP or DONE is ignored.
- DONE state:
  - dump_done=1, dump_valid=0; counters frozen.
  - Exit only via rst.
- rd_data stays usable in every state.

Decomposition:
- Shared package perf_pkg: state encoding constants (ST_RUN, ST_DUMP, ST_DONE) and counter index constants (IDX_CYCLE=0, IDX_INST=1, IDX_EVT0=2).
- One natural sub-module, perf_counter_cell:
  - Parameters CNT_W and SATURATE.
  - Inputs: inc, clr, frz.
  - Outputs: the counter value and a sticky ovf flag.
  - Instantiated NUM_CNT times via generate.
- The FSM, dump sequencer and read mux live in the top module.

Test Plan:
1. rst 1 cycle, enable=1, idle 10 cycles -> rd_idx=0 reads 10; rd_idx=1 reads 0; ovf=0; state=RUN.
2. retire high 5 cycles, evt[1] high 3 cycles, evt[1] overlapping retire 2 of those -> inst=5, event1 (idx 3)=3, other events 0; idx 7 (>= NUM_CNT=6) reads 0.
3. CNT_W=8, SATURATE=1, evt[0] high 300 cycles -> idx2=255, ovf[2]=1. SATURATE=0, same stimulus -> idx2=44, ovf[2]=1.
4. clr and retire asserted together after inst=7 -> inst=0 next cycle, ovf=0; clr asserted in DUMP -> no change.
5. halt with retire=0 after 20 cycles, dump_ready toggling 1,0,1... -> inst includes halt (+1). Six words idx 0..5 with stable data during ready=0, counter values frozen, then dump_done=1, state=DONE.
6. rst asserted mid-DUMP at dump_idx=3 -> next cycle state=RUN, all counters 0, dump_valid=0, dump_done=0.
